mod_updown_counter: RTL and testbench

Parametrised up/down modulo counter. Successor to the fixed 10-bit free-running demo counter.
Adds configurable width and modulus, count direction, synchronous load/clear, wrap or saturate mode, and a terminal-count pulse plus a sticky overflow flag.
Used as a general timebase/event counter; the TC output chains into downstream counters or timers.

---
 rtl/mod_updown_counter.sv | 129 ++++++++++++
 tb/tb_mod_updown_counter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter with synchronous load/clear,
// wrap or saturate at the boundary, a one-cycle terminal-count pulse
// and a sticky overflow flag.
// Optional CE prescaler: define COUNTER_PRESCALE_EN.
module mod_updown_counter #(
  parameter int     WIDTH    = 10,
  parameter longint MODULO   = 1000,
  parameter bit     SATURATE = 1'b0,
  parameter int     PRESCALE = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             UP_DN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             CLEAR,
  output logic [WIDTH-1:0] COUNTER,
  output logic             TC,
  output logic             OVF
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be in 2..32");
  end
  if (MODULO < 2 || MODULO > (longint'(1) << WIDTH)) begin : g_bad_modulo
    $error("mod_updown_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mod_updown_counter: PRESCALE must be >= 1");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             armed_q, armed_d;
  logic             step;

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;

  // Prescaler: counts CE-qualified cycles, restarts on clear/load
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pre_q <= '0;
    end else if (CLEAR || LOAD) begin
      pre_q <= '0;
    end else if (CE) begin
      pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    end
  end

  assign step = CE && (pre_q == PRE_LAST);
`else
  assign step = CE;
`endif

  // Next-state logic: clear > load > count step
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    armed_d = armed_q;
    if (CLEAR) begin
      count_d = '0;
      ovf_d   = 1'b0;
      armed_d = 1'b1;
    end else if (LOAD) begin
      count_d = (LOAD_VAL > MAX) ? MAX : LOAD_VAL;
      armed_d = 1'b1;
    end else if (step) begin
      if (UP_DN) begin
        if (count_q == MAX) begin
          ovf_d = 1'b1;
          if (SATURATE) begin
            // Holding at the boundary: pulse only on the first arrival
            tc_d    = armed_q;
            armed_d = 1'b0;
          end else begin
            count_d = '0;
            tc_d    = 1'b1;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
          armed_d = 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          ovf_d = 1'b1;
          if (SATURATE) begin
            tc_d    = armed_q;
            armed_d = 1'b0;
          end else begin
            count_d = MAX;
            tc_d    = 1'b1;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
          armed_d = 1'b1;
        end
      end
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      armed_q <= armed_d;
    end
  end

  assign COUNTER = count_q;
  assign TC      = tc_q;
  assign OVF     = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: one wrapping instance, one
// saturating instance and one PRESCALE=4 instance with its own CE.
module tb_mod_updown_counter;

`ifdef COUNTER_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, ce, ce_p, up, load, clear;
  logic [9:0] lv;

  logic [9:0] cnt_w, cnt_s, cnt_p;
  logic       tc_w, tc_s, tc_p, ovf_w, ovf_s, ovf_p;

  int total = 0;
  int bad   = 0;
  int ce_edges;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(10), .MODULO(1000), .SATURATE(1'b0), .PRESCALE(1)) u_wrap (
    .CLOCK(clk), .RESET(rst), .CE(ce), .UP_DN(up), .LOAD(load), .LOAD_VAL(lv),
    .CLEAR(clear), .COUNTER(cnt_w), .TC(tc_w), .OVF(ovf_w)
  );

  mod_updown_counter #(.WIDTH(10), .MODULO(1000), .SATURATE(1'b1), .PRESCALE(1)) u_sat (
    .CLOCK(clk), .RESET(rst), .CE(ce), .UP_DN(up), .LOAD(load), .LOAD_VAL(lv),
    .CLEAR(clear), .COUNTER(cnt_s), .TC(tc_s), .OVF(ovf_s)
  );

  mod_updown_counter #(.WIDTH(10), .MODULO(1000), .SATURATE(1'b0), .PRESCALE(4)) u_pre (
    .CLOCK(clk), .RESET(rst), .CE(ce_p), .UP_DN(up), .LOAD(load), .LOAD_VAL(lv),
    .CLEAR(clear), .COUNTER(cnt_p), .TC(tc_p), .OVF(ovf_p)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks count/tc/ovf of the wrap and saturate instances
  task automatic chk2(input string tag,
                      input int unsigned cw, input int unsigned tw, input int unsigned ow,
                      input int unsigned cs, input int unsigned ts, input int unsigned os);
    check({tag, ".cnt_w"}, 32'(cnt_w), cw);
    check({tag, ".tc_w"},  32'(tc_w),  tw);
    check({tag, ".ovf_w"}, 32'(ovf_w), ow);
    check({tag, ".cnt_s"}, 32'(cnt_s), cs);
    check({tag, ".tc_s"},  32'(tc_s),  ts);
    check({tag, ".ovf_s"}, 32'(ovf_s), os);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; ce_p = 1'b0; up = 1'b1;
    load = 1'b0; clear = 1'b0; lv = '0;

    // Reset held, clock running
    #100;
    chk2("reset", 0, 0, 0, 0, 0, 0);
    check("reset.cnt_p", 32'(cnt_p), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Up-count from 0
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk2("up", i, 0, 0, i, 0, 0);
    end

    // Wrap / saturate at the top
    load = 1'b1; lv = 10'd998;
    tick(); chk2("ld998", 998, 0, 0, 998, 0, 0);
    load = 1'b0;
    tick(); chk2("top0", 999, 0, 0, 999, 0, 0);
    tick(); chk2("top1", 0, 1, 1, 999, 1, 1);
    tick(); chk2("top2", 1, 0, 1, 999, 0, 1);

    // Clear beats load
    clear = 1'b1; load = 1'b1; lv = 10'd500;
    tick(); chk2("clr_ld", 0, 0, 0, 0, 0, 0);
    clear = 1'b0;

    // Down through zero, then re-arm
    lv = 10'd1; up = 1'b0;
    tick(); chk2("ld1", 1, 0, 0, 1, 0, 0);
    load = 1'b0;
    tick(); chk2("dn0", 0, 0, 0, 0, 0, 0);
    tick(); chk2("dn1", 999, 1, 1, 0, 1, 1);
    tick(); chk2("dn2", 998, 0, 1, 0, 0, 1);
    tick(); chk2("dn3", 997, 0, 1, 0, 0, 1);
    up = 1'b1;
    tick(); chk2("rearm_up", 998, 0, 1, 1, 0, 1);
    up = 1'b0;
    tick(); chk2("rearm_dn", 997, 0, 1, 0, 0, 1);
    tick(); chk2("rearm_tc", 996, 0, 1, 0, 1, 1);

    // CE low holds count and drops TC
    ce = 1'b0;
    tick(); chk2("ce_off", 996, 0, 1, 0, 0, 1);
    ce = 1'b1;

    // Load clamp, then in-range load keeps OVF
    load = 1'b1; lv = 10'd1023;
    tick(); chk2("clamp", 999, 0, 1, 999, 0, 1);
    lv = 10'd437;
    tick(); chk2("ld437", 437, 0, 1, 437, 0, 1);
    load = 1'b0; up = 1'b1;

    // Asynchronous reset between edges
    #3;
    rst = 1'b1;
    #1;
    chk2("async_rst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick(); chk2("resume", 1, 0, 0, 1, 0, 0);

    // Prescaled instance: continuous CE, then alternating CE
    ce_edges = 0;
    for (int i = 0; i < 12; i++) begin
      ce_p = 1'b1;
      tick();
      ce_edges++;
      check("pre_cont", 32'(cnt_p), 32'(ce_edges / PS));
    end
    for (int i = 0; i < 16; i++) begin
      ce_p = (i % 2 == 0);
      tick();
      if (ce_p) ce_edges++;
      check("pre_tog", 32'(cnt_p), 32'(ce_edges / PS));
    end
    ce_p = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
